// File: rtl/dlx_mem_arbiter.sv
// rtl/dlx_mem_arbiter.sv - shares one memory port between DLX fetch and data ports (optional starvation guard: ARB_STARVE_GUARD_EN)
module dlx_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int TIMEOUT    = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_issue,
  output logic              o_if_ready,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic              i_d_issue,
  input  logic              i_d_rnw,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ready,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_issue,
  output logic              o_mem_rnw,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_err_timeout
);

  // Timeout counter only ever needs to reach TIMEOUT-1, where it aborts.
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  // A zero-cycle timeout or a zero starvation budget makes no sense.
  if (TIMEOUT < 2 || STARVE_MAX < 1) begin : g_param_check
    $error("dlx_mem_arbiter: TIMEOUT must be >= 2 and STARVE_MAX >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IF,
    S_WAIT_D,
    S_RESP_IF,
    S_RESP_D
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TW-1:0]     r_tcnt;
  logic [TW-1:0]     w_tcnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_rnw;
  logic              w_rnw_nxt;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] w_if_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata;
  logic [DATA_W-1:0] w_d_rdata_nxt;
  logic              r_err;
  logic              w_err_nxt;

  logic              w_grant_any;
  logic              w_grant_if;
  logic [DATA_W-1:0] w_resp_data;

  assign w_grant_any = (r_state == S_IDLE) && (i_if_issue || i_d_issue);

  // An aborted transaction returns all-ones instead of whatever is on the bus.
  assign w_resp_data = i_mem_ready ? i_mem_rdata : {DATA_W{1'b1}};

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_nxt;

  // Fetch wins a tie only once STARVE_MAX data grants have passed it by.
  always_comb begin
    w_grant_if = i_if_issue && (!i_d_issue || (r_starve == STARVE_TOP));
  end

  // Count data grants that overtook a waiting fetch; saturate, clear on fetch grant.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_grant_any) begin
      if (w_grant_if) begin
        w_starve_nxt = '0;
      end else if (i_if_issue && (r_starve != STARVE_TOP)) begin
        w_starve_nxt = r_starve + 1'b1;
      end
    end
  end

  // Starve counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_nxt;
    end
  end
`else
  // Strict fixed priority: data port always wins a tie.
  always_comb begin
    w_grant_if = i_if_issue && !i_d_issue;
  end
`endif

  // Next-state and datapath update for the single outstanding transaction.
  always_comb begin
    w_state_nxt    = r_state;
    w_tcnt_nxt     = r_tcnt;
    w_addr_nxt     = r_addr;
    w_rnw_nxt      = r_rnw;
    w_wdata_nxt    = r_wdata;
    w_if_rdata_nxt = r_if_rdata;
    w_d_rdata_nxt  = r_d_rdata;
    w_err_nxt      = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any) begin
          w_tcnt_nxt = '0;
          if (w_grant_if) begin
            // Fetches are always reads; keep the write bus quiet.
            w_addr_nxt  = i_if_addr;
            w_rnw_nxt   = 1'b1;
            w_wdata_nxt = '0;
            w_state_nxt = S_WAIT_IF;
          end else begin
            w_addr_nxt  = i_d_addr;
            w_rnw_nxt   = i_d_rnw;
            w_wdata_nxt = i_d_wdata;
            w_state_nxt = S_WAIT_D;
          end
        end
      end
      S_WAIT_IF, S_WAIT_D: begin
        if (i_mem_ready || (r_tcnt == TO_LAST)) begin
          // A late answer on the very last allowed cycle still counts as a completion.
          if (!i_mem_ready) begin
            w_err_nxt = 1'b1;
          end
          if (r_state == S_WAIT_IF) begin
            w_if_rdata_nxt = w_resp_data;
            w_state_nxt    = S_RESP_IF;
          end else begin
            w_d_rdata_nxt  = w_resp_data;
            w_state_nxt    = S_RESP_D;
          end
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      S_RESP_IF, S_RESP_D: begin
        // Requests are ignored here, guaranteeing an idle memory cycle between transactions.
        w_tcnt_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_tcnt_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset silently drops any transaction in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tcnt     <= '0;
      r_addr     <= '0;
      r_rnw      <= 1'b0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_addr     <= w_addr_nxt;
      r_rnw      <= w_rnw_nxt;
      r_wdata    <= w_wdata_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_d_rdata  <= w_d_rdata_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign o_mem_issue   = (r_state == S_WAIT_IF) || (r_state == S_WAIT_D);
  assign o_if_ready    = (r_state == S_RESP_IF);
  assign o_d_ready     = (r_state == S_RESP_D);
  assign o_busy        = (r_state != S_IDLE);
  assign o_mem_addr    = r_addr;
  assign o_mem_rnw     = r_rnw;
  assign o_mem_wdata   = r_wdata;
  assign o_if_rdata    = r_if_rdata;
  assign o_d_rdata     = r_d_rdata;
  assign o_err_timeout = r_err;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// tb/tb_dlx_mem_arbiter.sv - randomized self-checking bench with a transaction-level reference model
module tb_dlx_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TO = 8;
  localparam int SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] if_addr;
  logic          if_issue;
  logic          o_if_ready;
  logic [DW-1:0] o_if_rdata;
  logic [AW-1:0] d_addr;
  logic          d_issue;
  logic          d_rnw;
  logic [DW-1:0] d_wdata;
  logic          o_d_ready;
  logic [DW-1:0] o_d_rdata;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_issue;
  logic          o_mem_rnw;
  logic [DW-1:0] o_mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          o_busy;
  logic          o_err;

  dlx_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .STARVE_MAX(SM)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_addr(if_addr), .i_if_issue(if_issue), .o_if_ready(o_if_ready), .o_if_rdata(o_if_rdata),
    .i_d_addr(d_addr), .i_d_issue(d_issue), .i_d_rnw(d_rnw), .i_d_wdata(d_wdata),
    .o_d_ready(o_d_ready), .o_d_rdata(o_d_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_issue(o_mem_issue), .o_mem_rnw(o_mem_rnw),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_busy(o_busy), .o_err_timeout(o_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the current transaction as a timeline counted from its grant edge.
  // Cycle k=1..m_nwait has the memory request up, cycle m_nwait+1 is the ready pulse.
  int            m_port;   // 0 none, 1 fetch, 2 data
  int            m_k;
  int            m_nwait;
  int            m_lat;    // wait-cycle index at which the memory answers
  bit            m_to;
  logic [AW-1:0] m_addr;
  logic          m_rnw;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_mem;
  logic [DW-1:0] e_if_rdata;
  logic [DW-1:0] e_d_rdata;
  logic          e_err;
  int            m_starve;

  bit            rand_mode;
  bit            noise;
  int            dir_lat;
  logic [DW-1:0] dir_mem;
  bit            drop_if;
  bit            drop_d;
  int            n_issue;
  int            n_ifr;
  int            n_dr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 3);
    if (r == 6) return TO - 1;
    if (r == 7) return TO;
    if (r == 8) return $urandom_range(TO + 1, TO + 4);
    return $urandom_range(4, TO - 2);
  endfunction

  // Advance the model across the coming clock edge using the inputs as they stand.
  task automatic model_edge();
    bit take_if;
    bit take_d;
    if (rst) begin
      m_port = 0; m_k = 0;
      m_addr = '0; m_rnw = 1'b0; m_wdata = '0;
      e_if_rdata = '0; e_d_rdata = '0; e_err = 1'b0;
      m_starve = 0;
    end else if (m_port == 0) begin
      take_d  = d_issue;
      take_if = if_issue && !d_issue;
`ifdef ARB_STARVE_GUARD_EN
      if (if_issue && d_issue && m_starve == SM) begin
        take_if = 1'b1;
        take_d  = 1'b0;
      end
`endif
      if (take_if || take_d) begin
        if (take_if) begin
          m_port = 1; m_addr = if_addr; m_rnw = 1'b1; m_wdata = '0;
          m_starve = 0;
        end else begin
          m_port = 2; m_addr = d_addr; m_rnw = d_rnw; m_wdata = d_wdata;
          if (if_issue && m_starve < SM) m_starve++;
        end
        if (rand_mode) begin
          m_lat = pick_lat();
          m_mem = {$urandom, $urandom};
        end else begin
          m_lat = dir_lat;
          m_mem = dir_mem;
        end
        m_to    = (m_lat >= TO);
        m_nwait = m_to ? TO : m_lat + 1;
        m_k     = 1;
      end
    end else if (m_k == m_nwait + 1) begin
      m_port = 0;
      m_k    = 0;
    end else begin
      m_k++;
      if (m_k == m_nwait + 1) begin
        if (m_port == 1) e_if_rdata = m_to ? {DW{1'b1}} : m_mem;
        else             e_d_rdata  = m_to ? {DW{1'b1}} : m_mem;
        if (m_to) e_err = 1'b1;
      end
    end
  endtask

  task automatic compare();
    bit in_wait;
    bit in_resp;
    in_wait = (m_port != 0) && (m_k <= m_nwait);
    in_resp = (m_port != 0) && (m_k == m_nwait + 1);
    chk("busy",      o_busy,      m_port != 0);
    chk("mem_issue", o_mem_issue, in_wait);
    chk("if_ready",  o_if_ready,  in_resp && m_port == 1);
    chk("d_ready",   o_d_ready,   in_resp && m_port == 2);
    chk("mem_addr",  o_mem_addr,  m_addr);
    chk("mem_rnw",   o_mem_rnw,   m_rnw);
    chk("mem_wdata", o_mem_wdata, m_wdata);
    chk("if_rdata",  o_if_rdata,  e_if_rdata);
    chk("d_rdata",   o_d_rdata,   e_d_rdata);
    chk("err",       o_err,       e_err);
  endtask

  task automatic drive_mem();
    if (m_port != 0 && m_k <= m_nwait) begin
      mem_ready = (m_k - 1 == m_lat);
      mem_rdata = mem_ready ? m_mem : {$urandom, $urandom};
    end else begin
      mem_ready = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
      mem_rdata = {$urandom, $urandom};
    end
  endtask

  // One clock: model edge, DUT edge, check, then requester drop and memory drive.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
    if (o_mem_issue) n_issue++;
    if (o_if_ready)  n_ifr++;
    if (o_d_ready)   n_dr++;
    if (drop_if) begin if_issue = 1'b0; drop_if = 1'b0; end
    if (drop_d)  begin d_issue  = 1'b0; drop_d  = 1'b0; end
    if (m_port == 1 && m_k == m_nwait + 1) drop_if = 1'b1;
    if (m_port == 2 && m_k == m_nwait + 1) drop_d  = 1'b1;
    drive_mem();
  endtask

  // Cycles from the issue cycle (counted as 1) up to the ready cycle; -1 if the bound expires.
  task automatic wait_ready(input bit is_if, input int maxc, output int cyc);
    cyc = 1;
    for (int i = 0; i < maxc; i++) begin
      step();
      cyc++;
      if (is_if ? o_if_ready : o_d_ready) return;
    end
    cyc = -1;
  endtask

  int cyc;
  int lows;
  int nseq;
  int seq [10];

  initial begin
    rst = 1'b1; if_addr = '0; if_issue = 1'b0; d_addr = '0; d_issue = 1'b0;
    d_rnw = 1'b0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    m_port = 0; m_k = 0; m_nwait = 0; m_lat = 0; m_to = 1'b0;
    m_addr = '0; m_rnw = 1'b0; m_wdata = '0; m_mem = '0;
    e_if_rdata = '0; e_d_rdata = '0; e_err = 1'b0; m_starve = 0;
    rand_mode = 1'b0; noise = 1'b0; dir_lat = 0; dir_mem = '0;
    drop_if = 1'b0; drop_d = 1'b0; n_issue = 0; n_ifr = 0; n_dr = 0;

    step();
    step();
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_err", o_err, 1'b0);
    rst = 1'b0;
    step();

    // Single fetch, memory answers after two wait cycles.
    dir_lat = 2; dir_mem = 64'h0123456789ABCDEF;
    if_addr = 32'h100; if_issue = 1'b1;
    n_issue = 0; n_dr = 0;
    wait_ready(1'b1, 20, cyc);
    chk("t1_latency", cyc, 5);
    chk("t1_issue_cycles", n_issue, 3);
    chk("t1_if_rdata", o_if_rdata, 64'h0123456789ABCDEF);
    chk("t1_mem_addr", o_mem_addr, 32'h100);
    chk("t1_mem_rnw", o_mem_rnw, 1'b1);
    step();
    chk("t1_no_d_ready", n_dr, 0);

    // Simultaneous requests: data first, then fetch.
    dir_lat = 0; dir_mem = 64'h1111;
    if_addr = 32'h200; if_issue = 1'b1;
    d_addr = 32'h40; d_rnw = 1'b0; d_wdata = 64'hDEAD; d_issue = 1'b1;
    step();
    chk("t2_d_first_rnw", o_mem_rnw, 1'b0);
    chk("t2_d_first_wdata", o_mem_wdata, 64'hDEAD);
    chk("t2_d_first_addr", o_mem_addr, 32'h40);
    step();
    chk("t2_d_ready", o_d_ready, 1'b1);
    chk("t2_resp_no_issue", o_mem_issue, 1'b0);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_mem_issue) break;
      lows++;
    end
    chk("t2_idle_gap", lows, 1);
    chk("t2_if_addr", o_mem_addr, 32'h200);
    chk("t2_if_wdata", o_mem_wdata, 64'h0);
    step();
    chk("t2_if_ready", o_if_ready, 1'b1);
    step();

    // Timeout: memory never answers a data read.
    dir_lat = 100;
    d_addr = 32'h80; d_rnw = 1'b1; d_wdata = 64'h0; d_issue = 1'b1;
    n_issue = 0;
    wait_ready(1'b0, 30, cyc);
    chk("t3_latency", cyc, 10);
    chk("t3_issue_cycles", n_issue, 8);
    chk("t3_err", o_err, 1'b1);
    chk("t3_d_rdata", o_d_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    dir_lat = 1; dir_mem = 64'hCAFE;
    if_addr = 32'h104; if_issue = 1'b1;
    wait_ready(1'b1, 20, cyc);
    chk("t3_fetch_after", o_if_rdata, 64'hCAFE);
    chk("t3_err_sticky", o_err, 1'b1);
    step();

    // Reset during a data wait.
    dir_lat = 100;
    d_addr = 32'h300; d_rnw = 1'b1; d_issue = 1'b1;
    step(); step(); step();
    rst = 1'b1; d_issue = 1'b0; n_dr = 0;
    step();
    chk("t5_issue_low", o_mem_issue, 1'b0);
    chk("t5_busy_low", o_busy, 1'b0);
    chk("t5_err_clear", o_err, 1'b0);
    rst = 1'b0;
    step();
    chk("t5_no_d_ready", n_dr, 0);
    dir_lat = 0; dir_mem = 64'h5555_AAAA_0000_FFFF;
    d_addr = 32'h304; d_rnw = 1'b1; d_issue = 1'b1;
    wait_ready(1'b0, 20, cyc);
    chk("t5_latency", cyc, 3);
    chk("t5_d_rdata", o_d_rdata, 64'h5555_AAAA_0000_FFFF);
    step();

    // Both ports requesting continuously.
    rst = 1'b1; step(); rst = 1'b0;
    dir_lat = 0; dir_mem = 64'h77;
    if_addr = 32'h400; if_issue = 1'b1;
    d_addr = 32'h500; d_rnw = 1'b1; d_issue = 1'b1;
    nseq = 0;
    for (int i = 0; i < 200 && nseq < 10; i++) begin
      step();
      if (o_d_ready)  begin seq[nseq] = 2; nseq++; end
      if (o_if_ready) begin seq[nseq] = 1; nseq++; end
      if_issue = 1'b1;
      d_issue  = 1'b1;
    end
    chk("t4_count", nseq, 10);
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      chk("t4_order", seq[i], (i % 5 == 4) ? 1 : 2);
`else
      chk("t4_order", seq[i], 2);
`endif
    end
    if_issue = 1'b0; d_issue = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();

    // Zero-wait memory, alternating ports.
    dir_lat = 0;
    for (int i = 0; i < 6; i++) begin
      dir_mem = {32'h0, 32'(i + 1)};
      if (i % 2 == 0) begin
        if_addr = 32'h600 + 32'(i); if_issue = 1'b1;
      end else begin
        d_addr = 32'h700 + 32'(i); d_rnw = 1'(i % 4 == 1); d_wdata = 64'(i); d_issue = 1'b1;
      end
      wait_ready(i % 2 == 0, 10, cyc);
      chk("t6_latency", cyc, 3);
      step();
    end

    // Randomized traffic with noisy MEM_READY and occasional resets.
    rand_mode = 1'b1; noise = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (!if_issue && $urandom_range(0, 2) == 0) begin
        if_addr = $urandom; if_issue = 1'b1;
      end
      if (!d_issue && $urandom_range(0, 2) == 0) begin
        d_addr = $urandom; d_rnw = 1'($urandom_range(0, 1)); d_wdata = {$urandom, $urandom};
        d_issue = 1'b1;
      end
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dlx_mem_arbiter.md
Name: dlx_mem_arbiter

Overview:
- Shares one unified memory port between the DLX instruction-fetch port (IRAM side) and data port (DRAM side).
- Sits between the DLX core and a single ROMEM/RWMEM-style memory model.
- Each port uses the existing ISSUE/READY handshake.
- Arbitrates simultaneous requests, sequences a single outstanding memory transaction, and flags memories that never answer.

Parameters:
ADDR_W, 32, address width of all three ports
DATA_W, 64, data width (2*Data_size)
TIMEOUT, 64, max cycles MEM_ISSUE may stay high without MEM_READY (>=2)
STARVE_MAX, 4, consecutive data grants tolerated while a fetch waits (starvation guard only)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
IF_ADDR  in  ADDR_W  fetch address
IF_ISSUE  in  1  fetch request, held until IF_READY
IF_READY  out  1  one-cycle fetch-complete pulse
IF_RDATA  out  DATA_W  fetch data, valid when IF_READY=1
D_ADDR  in  ADDR_W  data address
D_ISSUE  in  1  data request, held until D_READY
D_RNW  in  1  1=read, 0=write
D_WDATA  in  DATA_W  write data
D_READY  out  1  one-cycle data-complete pulse
D_RDATA  out  DATA_W  read data, valid when D_READY=1 and D_RNW=1
MEM_ADDR  out  ADDR_W  memory address
MEM_ISSUE  out  1  memory request
MEM_RNW  out  1  memory read/write select
MEM_WDATA  out  DATA_W  memory write data
MEM_READY  in  1  memory completion
MEM_RDATA  in  DATA_W  memory read data
BUSY  out  1  high when state is not IDLE
ERR_TIMEOUT  out  1  sticky timeout flag, cleared only by RST

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0, starve counter 0. RST mid-transaction drops the transaction silently: no READY pulse, MEM_ISSUE low on the next cycle.
- Requester rules:
  - ADDR, RNW and WDATA stay stable while ISSUE is high.
  - ISSUE drops in the cycle after READY is sampled.
  - The arbiter ignores ISSUE during RESP.
- States:
  - IDLE:
    - Sample IF_ISSUE and D_ISSUE.
    - Both high: data port wins (fixed priority).
    - Latch the winner's ADDR, RNW and WDATA into output registers. IF grants force MEM_RNW=1 and MEM_WDATA=0.
    - Go to WAIT_IF or WAIT_D.
  - WAIT_x:
    - MEM_ISSUE=1; MEM_ADDR, MEM_RNW and MEM_WDATA held from the latch.
    - Timeout counter increments each cycle.
    - MEM_READY=1 at an edge: register MEM_RDATA into x_RDATA, go to RESP_x.
    - Counter reaches TIMEOUT-1 with no MEM_READY: set ERR_TIMEOUT, load x_RDATA with all-ones, go to RESP_x.
  - RESP_x:
    - x_READY=1 for exactly this cycle; MEM_ISSUE=0; counter cleared; go to IDLE.
    - Back-to-back requests therefore have at least one idle MEM_ISSUE cycle between them.
- Latency: ISSUE sampled at edge t. MEM_ISSUE is high from t+1. With MEM_READY high at the first edge after that, READY is high in cycle t+2..t+3. Minimum is 3 cycles from issue to ready.
- Data hold:
  - x_RDATA holds its value after READY until the next completion on that port.
  - D_RDATA is undefined-but-stable after writes; it is loaded with MEM_RDATA.
- Wrap-around: the timeout counter never wraps; it saturates at TIMEOUT-1 and triggers the abort.
- A MEM_READY arriving in IDLE or RESP is ignored.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined: a starve counter increments on each data grant made while IF_ISSUE=1.
  - When the counter equals STARVE_MAX and both ports request in IDLE, IF wins.
  - The counter clears on any IF grant.
  - The counter saturates at STARVE_MAX.
- Undefined: counter logic absent; strict data-port priority always.

Test Plan:
1. Single fetch: IF_ISSUE=1, IF_ADDR=0x100, memory MEM_READY after 2 wait cycles with MEM_RDATA=0x0123456789ABCDEF -> MEM_ADDR=0x100, MEM_RNW=1, IF_READY one cycle, IF_RDATA=0x0123456789ABCDEF, D_READY never high.
2. Simultaneous: IF_ISSUE=1 and D_ISSUE=1 (write 0xDEAD to 0x40) in the same cycle -> data granted first (MEM_RNW=0, MEM_WDATA=0xDEAD), D_READY, then fetch served, IF_READY; MEM_ISSUE low for one cycle between.
3. Timeout: D_ISSUE read, MEM_READY held 0, TIMEOUT=8 -> MEM_ISSUE high 8 cycles, ERR_TIMEOUT=1 sticky, D_READY pulse with D_RDATA=all-ones; next fetch completes normally with ERR_TIMEOUT still 1.
4. Starvation (ARB_STARVE_GUARD_EN, STARVE_MAX=4): IF_ISSUE and D_ISSUE continuously high -> 4 data grants, then 1 IF grant, pattern repeats; without the macro IF_READY never asserts.
5. Reset mid-op: RST=1 during WAIT_D -> next cycle MEM_ISSUE=0, BUSY=0, no D_READY, ERR_TIMEOUT=0; new request after reset completes in 3 cycles with a zero-wait memory.
6. Zero-wait memory: MEM_READY tied 1, alternating IF/D requests -> each READY exactly 3 cycles after its ISSUE, BUSY low only in IDLE cycles.
